// File: rtl/nibble_serial_add32.sv
// ----------------------------------------------------------------------------
// nibble_serial_add32
//
// Purpose:
//   32-bit adder that adds SLICE_W bits per clock cycle. Operands are accepted
//   with a valid/ready handshake. The sum is built up over 32/SLICE_W cycles,
//   one slice per cycle, using a single SLICE_W-bit ripple adder and a carry
//   register. The 33-bit result {carry_out, sum[31:0]} is presented with a
//   valid/ready handshake.
//
// Ports:
//   clk        in   1   clock; all state updates on the rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   a, b and cin are valid
//   in_ready   out  1   block can accept operands (IDLE only)
//   a          in   32  augend
//   b          in   32  addend
//   cin        in   1   carry into bit 0
//   out_valid  out  1   sum is valid (DONE only)
//   out_ready  in   1   consumer accepts sum
//   sum        out  33  {carry_out, sum[31:0]}
//   busy       out  1   high while slices are being added (RUN only)
//
// SLICE_W must divide 32 evenly.
// ----------------------------------------------------------------------------
module nibble_serial_add32 #(
    parameter int SLICE_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [32:0] sum,
    output logic        busy
);

    localparam int N_SLICES = 32 / SLICE_W;
    localparam int K_W      = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_run;
    logic               w_last;

    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic               r_carry;
    logic [K_W-1:0]     r_k;
    logic [32:0]        r_sum;
    logic [32:0]        w_sum_next;
    logic [SLICE_W:0]   w_slice_sum;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_k == K_LAST) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                // Returning to IDLE here means the earliest new accept is the
                // edge after the output handshake, never the same edge.
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_run  = (r_state == RUN);
    assign w_last = w_run && (r_k == K_LAST);

    // ------------------------------------------------------------------
    // Slice adder
    // The operand registers shift right by one slice per RUN cycle, so the
    // current slice k is always in the low SLICE_W bits and no wide read mux
    // is needed.
    // ------------------------------------------------------------------
    assign w_slice_sum = {1'b0, r_a[SLICE_W-1:0]}
                       + {1'b0, r_b[SLICE_W-1:0]}
                       + {{SLICE_W{1'b0}}, r_carry};

    // Only slice k of the result changes in a RUN cycle; every other slice,
    // including results left over from the previous operation, holds.
    genvar gi;
    generate
        for (gi = 0; gi < N_SLICES; gi++) begin : g_slice
            localparam logic [K_W-1:0] SLICE_IDX = K_W'(gi);
            assign w_sum_next[gi*SLICE_W +: SLICE_W] =
                (w_run && (r_k == SLICE_IDX)) ? w_slice_sum[SLICE_W-1:0]
                                              : r_sum[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign w_sum_next[32] = w_last ? w_slice_sum[SLICE_W] : r_sum[32];

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_sum   <= '0;
        end else begin
            r_sum <= w_sum_next;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_k     <= '0;
            end else if (w_run) begin
                r_a     <= r_a >> SLICE_W;
                r_b     <= r_b >> SLICE_W;
                r_carry <= w_slice_sum[SLICE_W];
                r_k     <= r_k + 1'b1;
            end
        end
    end

    assign sum = r_sum;

endmodule
